// File: rtl/game_timer_bcd.sv
// Elapsed play-time counter in BCD (HH:MM:SS) with a best-time record.
// It feeds the current-time row and the best-time row of the on-screen renderer.
module game_timer_bcd #(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned CNT_W    = 27
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       finish,
  input  logic       clear,
  input  logic       PAUSE_sw,
  output logic       tick_1Hz,
  output logic [3:0] sec_1s,
  output logic [3:0] sec_10s,
  output logic [3:0] min_1s,
  output logic [3:0] min_10s,
  output logic [3:0] hr_1s,
  output logic [3:0] hr_10s,
  output logic [3:0] best_sec_1s,
  output logic [3:0] best_sec_10s,
  output logic [3:0] best_min_1s,
  output logic [3:0] best_min_10s,
  output logic [3:0] best_hr_1s,
  output logic [3:0] best_hr_10s,
  output logic       best_valid,
  output logic       running,
  output logic       overflow
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_PAUSED = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [CNT_W-1:0] PRESC_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [23:0]      TIME_MAX  = 24'h99_5959;

  logic [1:0]       state, state_nx;
  logic [CNT_W-1:0] presc;
  logic             tick, at_max, best_upd;
  logic [23:0]      cur_word, best_word, inc_word;

  always_comb begin
    cur_word  = {hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s};
    best_word = {best_hr_10s, best_hr_1s, best_min_10s, best_min_1s,
                 best_sec_10s, best_sec_1s};
    at_max    = (cur_word == TIME_MAX);
    tick      = !clear && (state == S_RUN) && (presc == PRESC_MAX);
  end

  // Ripple-carry BCD increment; the hr_10s wrap is unreachable because
  // 99:59:59 saturates before this value is used.
  always_comb begin
    inc_word = cur_word;
    if (sec_1s != 4'd9) inc_word[3:0] = sec_1s + 4'd1;
    else begin
      inc_word[3:0] = '0;
      if (sec_10s != 4'd5) inc_word[7:4] = sec_10s + 4'd1;
      else begin
        inc_word[7:4] = '0;
        if (min_1s != 4'd9) inc_word[11:8] = min_1s + 4'd1;
        else begin
          inc_word[11:8] = '0;
          if (min_10s != 4'd5) inc_word[15:12] = min_10s + 4'd1;
          else begin
            inc_word[15:12] = '0;
            if (hr_1s != 4'd9) inc_word[19:16] = hr_1s + 4'd1;
            else begin
              inc_word[19:16] = '0;
              inc_word[23:20] = hr_10s + 4'd1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    best_upd = 1'b0;
    if (clear) state_nx = S_IDLE;
    else begin
      case (state)
        S_IDLE:   if (start) state_nx = PAUSE_sw ? S_PAUSED : S_RUN;
        S_RUN:    if (finish) state_nx = S_DONE;
                  else if (PAUSE_sw) state_nx = S_PAUSED;
        S_PAUSED: if (finish) state_nx = S_DONE;
                  else if (!PAUSE_sw) state_nx = S_RUN;
        default:  state_nx = state;
      endcase
      best_upd = finish && (state == S_RUN || state == S_PAUSED) && !overflow &&
                 (!best_valid || cur_word < best_word);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      presc      <= '0;
      {hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s} <= '0;
      {best_hr_10s, best_hr_1s, best_min_10s, best_min_1s,
       best_sec_10s, best_sec_1s} <= TIME_MAX;
      best_valid <= 1'b0;
      overflow   <= 1'b0;
      tick_1Hz   <= 1'b0;
      running    <= 1'b0;
    end else begin
      state    <= state_nx;
      running  <= (state_nx == S_RUN);
      tick_1Hz <= tick;
      if (clear) begin
        presc    <= '0;
        {hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s} <= '0;
        overflow <= 1'b0;
      end else begin
        if (state == S_IDLE && start) presc <= '0;
        else if (state == S_RUN) presc <= tick ? '0 : presc + 1'b1;
        // A finish on the tick edge freezes the pre-tick value.
        if (tick && !finish) begin
          if (at_max) overflow <= 1'b1;
          else {hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s} <= inc_word;
        end
        if (best_upd) begin
          {best_hr_10s, best_hr_1s, best_min_10s, best_min_1s,
           best_sec_10s, best_sec_1s} <= cur_word;
          best_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_game_timer_bcd.sv
// Bench for game_timer_bcd: a seconds-based reference model predicts each tick into a
// queue that a forked monitor drains; directed scenarios are followed by random stimulus.
module tb_game_timer_bcd;

  localparam int TD     = 4;
  localparam int MAXS   = 359999;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

  typedef struct {
    int cyc;
    int secs;
  } exp_t;

  logic clk, reset_n, start, finish, clear, pause_sw;
  logic tick_1Hz, best_valid, running, overflow;
  logic [3:0] sec_1s, sec_10s, min_1s, min_10s, hr_1s, hr_10s;
  logic [3:0] best_sec_1s, best_sec_10s, best_min_1s, best_min_10s, best_hr_1s, best_hr_10s;
  logic [23:0] cur_w, best_w;

  assign cur_w  = {hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s};
  assign best_w = {best_hr_10s, best_hr_1s, best_min_10s, best_min_1s, best_sec_10s, best_sec_1s};

  game_timer_bcd #(.TICK_DIV(TD), .CNT_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .finish(finish), .clear(clear),
    .PAUSE_sw(pause_sw), .tick_1Hz(tick_1Hz),
    .sec_1s(sec_1s), .sec_10s(sec_10s), .min_1s(min_1s), .min_10s(min_10s),
    .hr_1s(hr_1s), .hr_10s(hr_10s),
    .best_sec_1s(best_sec_1s), .best_sec_10s(best_sec_10s), .best_min_1s(best_min_1s),
    .best_min_10s(best_min_10s), .best_hr_1s(best_hr_1s), .best_hr_10s(best_hr_10s),
    .best_valid(best_valid), .running(running), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t q[$];

  int m_state = M_IDLE, m_phase = 0, m_secs = 0, m_best = MAXS;
  bit m_bvalid = 0, m_ovf = 0;

  function automatic logic [23:0] to_bcd(input int s);
    int h, m, x;
    h = s / 3600;
    m = (s / 60) % 60;
    x = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic record_best();
    if (!m_ovf && (!m_bvalid || m_secs < m_best)) begin
      m_best   = m_secs;
      m_bvalid = 1'b1;
    end
  endtask

  task automatic model_step();
    bit   t;
    exp_t e;
    t = 1'b0;
    if (!reset_n) begin
      m_state = M_IDLE; m_phase = 0; m_secs = 0; m_best = MAXS; m_bvalid = 0; m_ovf = 0;
    end else if (clear) begin
      m_state = M_IDLE; m_phase = 0; m_secs = 0; m_ovf = 0;
    end else begin
      case (m_state)
        M_IDLE: if (start) begin
          m_phase = 0;
          m_state = pause_sw ? M_PAUSED : M_RUN;
        end
        M_RUN: begin
          t       = (m_phase == TD - 1);
          m_phase = (m_phase + 1) % TD;
          if (finish) begin
            record_best();
            m_state = M_DONE;
          end else begin
            if (t) begin
              if (m_secs == MAXS) m_ovf = 1'b1;
              else m_secs++;
            end
            if (pause_sw) m_state = M_PAUSED;
          end
        end
        M_PAUSED: begin
          if (finish) begin
            record_best();
            m_state = M_DONE;
          end else if (!pause_sw) m_state = M_RUN;
        end
        default: ;
      endcase
    end
    if (t) begin
      e.cyc  = cyc;
      e.secs = m_secs;
      q.push_back(e);
    end
  endtask

  task automatic check_all();
    check("time", 32'(cur_w), 32'(to_bcd(m_secs)));
    check("best", 32'(best_w), 32'(to_bcd(m_best)));
    check("best_valid", 32'(best_valid), 32'(m_bvalid));
    check("running", 32'(running), 32'(m_state == M_RUN));
    check("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_step();
    @(negedge clk);
    check_all();
    start  = 1'b0;
    finish = 1'b0;
    clear  = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (tick_1Hz) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL tick_spurious cycle=%0d actual=1 expected=0", cyc);
        end else begin
          e = q.pop_front();
          check("tick_cycle", 32'(cyc), 32'(e.cyc));
          check("tick_time", 32'(cur_w), 32'(to_bcd(e.secs)));
        end
      end else if (q.size() != 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL tick_missing cycle=%0d actual=0 expected=1 at %0d", cyc, e.cyc);
      end
    end
  endtask

  task automatic run_to(input int secs);
    clear = 1'b1; step();
    start = 1'b1; step();
    run(TD * secs);
    finish = 1'b1; step();
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; finish = 1'b0; clear = 1'b0; pause_sw = 1'b0;
    fork
      monitor();
    join_none

    run(2);
    check("rst_time", 32'(cur_w), 32'h0);
    check("rst_best", 32'(best_w), 32'h995959);
    check("rst_flags", 32'({best_valid, running, overflow}), 32'h0);
    reset_n = 1'b1;
    step();

    start = 1'b1; step();
    run(240);
    check("t_00_01_00", 32'(cur_w), 32'h000100);
    run(TD * (3599 - 60));
    check("t_00_59_59", 32'(cur_w), 32'h005959);
    run(TD);
    check("t_01_00_00", 32'(cur_w), 32'h010000);

    clear = 1'b1; step();
    start = 1'b1; step();
    run(6);
    pause_sw = 1'b1; run(20);
    check("paused_time", 32'(cur_w), 32'h000001);
    pause_sw = 1'b0; run(2);
    check("pause_resume", 32'(cur_w), 32'h000002);

    run_to(10);
    check("best_10", 32'(best_w), 32'h000010);
    check("best_valid_1", 32'(best_valid), 32'h1);
    run_to(12);
    check("best_kept_12", 32'(best_w), 32'h000010);
    run_to(7);
    check("best_7", 32'(best_w), 32'h000007);
    clear = 1'b1; step();
    check("best_after_clear", 32'(best_w), 32'h000007);

    start = 1'b1; step();
    run(19);
    finish = 1'b1; step();
    check("finish_on_tick", 32'(cur_w), 32'h000004);
    check("best_4", 32'(best_w), 32'h000004);
    clear = 1'b1; step();
    start = 1'b1; step();
    run(8);
    clear = 1'b1; finish = 1'b1; step();
    check("clear_finish_best", 32'(best_w), 32'h000004);
    check("clear_finish_time", 32'(cur_w), 32'h0);
    start = 1'b1; step();
    run(5);
    start = 1'b1; step();
    run(2);
    check("start_in_run", 32'({running, cur_w}), 32'h1000002);

    clear = 1'b1; step();
    pause_sw = 1'b1; start = 1'b1; step();
    force dut.hr_10s = 4'd9;  force dut.hr_1s = 4'd9;
    force dut.min_10s = 4'd5; force dut.min_1s = 4'd9;
    force dut.sec_10s = 4'd5; force dut.sec_1s = 4'd8;
    m_secs = MAXS - 1;
    step();
    release dut.hr_10s;  release dut.hr_1s;
    release dut.min_10s; release dut.min_1s;
    release dut.sec_10s; release dut.sec_1s;
    step();
    check("preload", 32'(cur_w), 32'h995958);
    pause_sw = 1'b0;
    run(1 + 2 * TD);
    check("sat_time", 32'(cur_w), 32'h995959);
    check("sat_ovf", 32'(overflow), 32'h1);
    finish = 1'b1; step();
    check("sat_best_kept", 32'(best_w), 32'h000004);
    clear = 1'b1; step();
    check("clear_ovf", 32'({overflow, cur_w}), 32'h0);
    start = 1'b1; step();
    run(5);
    reset_n = 1'b0; step();
    check("rst_run_time", 32'(cur_w), 32'h0);
    check("rst_run_best", 32'(best_w), 32'h995959);
    check("rst_run_flags", 32'({best_valid, running, overflow}), 32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      reset_n = ($urandom_range(0, 499) != 0);
      clear   = ($urandom_range(0, 59) == 0);
      finish  = ($urandom_range(0, 39) == 0);
      start   = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 14) == 0) pause_sw = ~pause_sw;
      step();
    end

    reset_n = 1'b1; pause_sw = 1'b0;
    run(TD + 2);
    check("tick_queue_empty", 32'(q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/game_timer_bcd.md
Name: game_timer_bcd

Overview:
Upstream stage of the on-screen time renderer. It counts elapsed play time in BCD as HH:MM:SS and holds a "best time" record. It supplies the current-time digit set (row 1) and the best-time digit set (row 2) that the renderer draws. It is controlled by the game FSM (start/finish/clear pulses) and the pause switch.

Parameters:
TICK_DIV, 100_000_000, clk cycles per elapsed second; bench uses 4.
CNT_W, 27, prescaler width; must satisfy 2^CNT_W >= TICK_DIV.

Ports:
clk  in  1  system clock; all logic on the rising edge.
reset_n  in  1  synchronous, active-low reset.
start  in  1  one-cycle pulse: begin timing.
finish  in  1  one-cycle pulse: level complete; freeze the time and evaluate the best time.
clear  in  1  one-cycle pulse: zero the current time and return to IDLE; the best time is kept.
PAUSE_sw  in  1  level; high suspends counting.
tick_1Hz  out  1  one-cycle pulse on each counted second.
sec_1s, sec_10s, min_1s, min_10s, hr_1s, hr_10s  out  4 each  current time, BCD.
best_sec_1s, best_sec_10s, best_min_1s, best_min_10s, best_hr_1s, best_hr_10s  out  4 each  best time, BCD.
best_valid  out  1  high once any best time has been recorded.
running  out  1  high in the RUN state.
overflow  out  1  sticky; set when the counter saturates at 99:59:59.

Behaviour:
- Reset (reset_n low at a clk edge): state IDLE; prescaler 0; all current digits 0; all best digits 9,5,9,5,9,9 (99:59:59); best_valid 0; overflow 0; tick_1Hz 0; running 0. All outputs are registered.
- States: IDLE, RUN, PAUSED, DONE.
- Input priority when several are asserted in one cycle: clear > finish > start > PAUSE_sw.
  - clear in any state -> IDLE. Current digits, prescaler and overflow go to 0. Best digits and best_valid are unchanged.
  - IDLE + start -> RUN if PAUSE_sw is low, otherwise -> PAUSED. Prescaler is set to 0.
  - RUN + PAUSE_sw high -> PAUSED. PAUSED + PAUSE_sw low -> RUN. The prescaler holds its value while paused, so partial seconds are preserved.
  - RUN or PAUSED + finish -> DONE, and the best-time update below fires.
  - start in RUN, PAUSED or DONE: ignored. finish in IDLE or DONE: ignored.
  - DONE: everything frozen; only clear or reset leaves it.
- Prescaler:
  - Increments only in RUN.
  - At TICK_DIV-1 it wraps to 0 and drives tick_1Hz high for exactly that cycle.
  - First tick occurs TICK_DIV cycles after RUN is entered.
- BCD increment on tick (takes effect on the same edge that registers tick_1Hz):
  - sec_1s counts 0..9 and carries into sec_10s, which counts 0..5 and carries into min_1s.
  - min_1s counts 0..9; min_10s counts 0..5 and carries into hr_1s.
  - hr_1s counts 0..9; hr_10s counts 0..9.
  - Rollover example: 00:59:59 -> 01:00:00.
  - Saturation: at 99:59:59 a tick leaves the value unchanged and sets overflow. The prescaler keeps running.
- finish in the same cycle as a counting tick: the increment is discarded. The frozen value is the pre-tick value, and tick_1Hz still pulses.
- Best-time update (on the finish edge):
  - Compare the packed 24-bit word {hr_10s,hr_1s,min_10s,min_1s,sec_10s,sec_1s} as an unsigned number; BCD ordering equals numeric ordering.
  - If best_valid is 0, or the current word is strictly less than the best word: best <= current and best_valid <= 1.
  - An equal time leaves the best unchanged.
  - If overflow is 1, no update occurs.
  - The updated best is visible one cycle after finish.
- running = (state == RUN), registered.
- Digit outputs never take values above their stated ranges.

Test Plan:
- Reset: reset_n low for 2 cycles -> current 00:00:00, best 99:59:59, best_valid=0, running=0, overflow=0.
- Count, TICK_DIV=4: start, run 240 cycles -> 60 tick_1Hz pulses exactly 4 cycles apart; time 00:01:00. Also preload 00:59:59 and apply one tick -> 01:00:00.
- Pause: start, 6 cycles, PAUSE_sw=1 for 20 cycles, release -> no ticks while paused; the next tick arrives 2 cycles after release; time 00:00:02 after that tick.
- Best tracking: run to 00:00:10, finish -> best 00:00:10, valid=1. clear, run to 00:00:12, finish -> best unchanged. clear, run to 00:00:07, finish -> best 00:00:07. In every case the best survives clear.
- Simultaneous events: finish on the cycle tick_1Hz fires at 00:00:04->05 -> frozen at 00:00:04. clear+finish in the same cycle -> IDLE with no best update. start while in RUN -> no effect.
- Saturation: preload 99:59:58, two ticks -> 99:59:59 with overflow=1; finish -> best unchanged. clear -> overflow=0, time 00:00:00. reset_n low during RUN -> full reset values next cycle.
